// File: rtl/time_counter_if.sv
// Purpose : groups the control inputs and BCD time outputs of time_counter into one bundle.
// Latency : none; this is wiring only.
// Backpressure : none; all signals are plain levels or one-cycle pulses.
// Ports:
//   clk_N, run, set_mode, inc                     -> towards the counter (master drives)
//   hour_h/l, min_h/l, sec_h/l, sec_tick, hour_pulse <- from the counter (slave drives)
interface time_counter_if;
    logic       clk_N;
    logic       run;
    logic [1:0] set_mode;
    logic       inc;
    logic [3:0] hour_h;
    logic [3:0] hour_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
    logic       sec_tick;
    logic       hour_pulse;

    modport master (
        output clk_N, run, set_mode, inc,
        input  hour_h, hour_l, min_h, min_l, sec_h, sec_l, sec_tick, hour_pulse
    );

    modport slave (
        input  clk_N, run, set_mode, inc,
        output hour_h, hour_l, min_h, min_l, sec_h, sec_l, sec_tick, hour_pulse
    );
endinterface

// File: rtl/time_counter.sv
// Purpose : BCD HH:MM:SS wall clock counted from a synchronised slow square wave, with pause and manual set.
// Latency : a clk_N rise updates the time registers on the 3rd clk edge; set/clear acts on the edge after inc.
// Backpressure : none; one tick per clk_N rise, at most one update per clk.
// Ports:
//   clk, rst_n : system clock and asynchronous active-low reset
//   tc (slave) : clk_N/run/set_mode/inc in; BCD digits, sec_tick and hour_pulse out (all registered)
module time_counter #(
    parameter bit H24    = 1'b1,
    parameter int RST_HH = 0,
    parameter int RST_MM = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    time_counter_if.slave  tc
);

    // In 12-hour mode there is no hour 0; a reset hour of 0 means midnight, shown as 12.
    localparam int         RST_H_EFF = (!H24 && RST_HH == 0) ? 12 : RST_HH;
    localparam logic [7:0] RST_HOUR  = {4'(RST_H_EFF / 10), 4'(RST_H_EFF % 10)};
    localparam logic [7:0] RST_MIN   = {4'(RST_MM / 10), 4'(RST_MM % 10)};

    typedef enum logic [1:0] {
        NORMAL = 2'b00,
        SET_H  = 2'b01,
        SET_M  = 2'b10,
        SET_S  = 2'b11
    } mode_e;

    logic       s1, s2, s3;
    logic       tick;
    mode_e      state;

    // Each field is {tens, units} BCD.
    logic [7:0] hour_q, min_q, sec_q;
    logic [7:0] hour_d, min_d, sec_d;
    logic       sec_tick_q, hour_pulse_q;
    logic       sec_tick_d, hour_pulse_d;

    // 00..59 increment with wrap.
    function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {(v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Hour increment: 23->00 in 24-hour mode, 12->01 in 12-hour mode (11->12 is an ordinary step).
    function automatic logic [7:0] hour_inc(input logic [7:0] v);
        logic [7:0] r;
        if (H24 && v == 8'h23) begin
            r = 8'h00;
        end else if (!H24 && v == 8'h12) begin
            r = 8'h01;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // The sync chain free-runs regardless of mode or run, so toggling those never
    // fabricates an edge.
    assign tick = s2 & ~s3;

    // Mode is taken straight from set_mode in the current cycle, so an inc pulse and a
    // tick arriving together with a mode change are judged against the new mode.
    always_comb begin
        state = mode_e'(tc.set_mode);
    end

    always_comb begin
        hour_d       = hour_q;
        min_d        = min_q;
        sec_d        = sec_q;
        sec_tick_d   = 1'b0;
        hour_pulse_d = 1'b0;
        case (state)
            NORMAL: begin
                if (tc.run && tick) begin
                    sec_d      = bcd60_inc(sec_q);
                    sec_tick_d = 1'b1;
                    if (sec_q == 8'h59) begin
                        min_d = bcd60_inc(min_q);
                        // Both fields wrapping is exactly the MM:SS = 00:00 condition.
                        if (min_q == 8'h59) begin
                            hour_d       = hour_inc(hour_q);
                            hour_pulse_d = 1'b1;
                        end
                    end
                end
            end
            SET_H: begin
                if (tc.inc) begin
                    hour_d = hour_inc(hour_q);
                end
            end
            SET_M: begin
                if (tc.inc) begin
                    min_d = bcd60_inc(min_q);
                end
            end
            SET_S: begin
                if (tc.inc) begin
                    sec_d = 8'h00;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            hour_q       <= RST_HOUR;
            min_q        <= RST_MIN;
            sec_q        <= 8'h00;
            sec_tick_q   <= 1'b0;
            hour_pulse_q <= 1'b0;
        end else begin
            s1           <= tc.clk_N;
            s2           <= s1;
            s3           <= s2;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            sec_tick_q   <= sec_tick_d;
            hour_pulse_q <= hour_pulse_d;
        end
    end

    assign tc.hour_h     = hour_q[7:4];
    assign tc.hour_l     = hour_q[3:0];
    assign tc.min_h      = min_q[7:4];
    assign tc.min_l      = min_q[3:0];
    assign tc.sec_h      = sec_q[7:4];
    assign tc.sec_l      = sec_q[3:0];
    assign tc.sec_tick   = sec_tick_q;
    assign tc.hour_pulse = hour_pulse_q;

endmodule
